// File: rtl/seq_mul_ctrl.sv
// rtl/seq_mul_ctrl.sv - unsigned shift-and-add multiplier sequencer (optional SEQ_MUL_ZERO_SKIP_EN)
module seq_mul_ctrl #(
    parameter int W = 8
) (
    input  logic           CLK,
    input  logic           RST_N,
    input  logic           START,
    input  logic [W-1:0]   A,
    input  logic [W-1:0]   B,
    output logic           BUSY,
    output logic           DONE,
    output logic [2*W-1:0] PRODUCT
);

    localparam int CW = $clog2(W) + 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(W - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ADD   = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]    state;
    logic [W-1:0]  mcand;
    logic [W-1:0]  acc;
    logic [W-1:0]  mq;
    logic          c;
    logic [CW-1:0] cnt;
    logic [W:0]    alu_sum;
    logic          load;

    // Shared ALU in ADD mode: the extra top bit is the carry-out kept in c.
    assign alu_sum = {1'b0, acc} + {1'b0, mcand};
    assign load    = START && ((state == S_IDLE) || (state == S_DONE));

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state <= S_IDLE;
            mcand <= '0;
            acc   <= '0;
            mq    <= '0;
            c     <= 1'b0;
            cnt   <= '0;
        end else if (load) begin
            mcand <= A;
            mq    <= B;
            acc   <= '0;
            c     <= 1'b0;
            cnt   <= '0;
            state <= S_ADD;
        end else begin
            case (state)
                S_ADD: begin
                    if (mq[0]) begin
                        {c, acc} <= alu_sum;
                        state    <= S_SHIFT;
                    end else begin
`ifdef SEQ_MUL_ZERO_SKIP_EN
                        // Nothing to add: fold the shift into this cycle.
                        {c, acc, mq} <= {1'b0, 1'b0, acc, mq[W-1:1]};
                        cnt          <= cnt + CW'(1);
                        state        <= (cnt == LAST_CNT) ? S_DONE : S_ADD;
`else
                        c     <= 1'b0;
                        state <= S_SHIFT;
`endif
                    end
                end
                S_SHIFT: begin
                    // Carry from the add drops into acc[W-1] here.
                    {c, acc, mq} <= {1'b0, c, acc, mq[W-1:1]};
                    cnt          <= cnt + CW'(1);
                    state        <= (cnt == LAST_CNT) ? S_DONE : S_ADD;
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign BUSY    = (state == S_ADD) || (state == S_SHIFT);
    assign DONE    = (state == S_DONE);
    assign PRODUCT = {acc, mq};

endmodule

// File: tb/tb_seq_mul_ctrl.sv
// tb/tb_seq_mul_ctrl.sv - directed self-checking bench for seq_mul_ctrl
module tb_seq_mul_ctrl;

    localparam int W = 8;

    logic           clk;
    logic           rst_n;
    logic           start;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           busy;
    logic           done;
    logic [2*W-1:0] product;

    int checks = 0;
    int errors = 0;

    seq_mul_ctrl #(.W(W)) dut (
        .CLK(clk),
        .RST_N(rst_n),
        .START(start),
        .A(a),
        .B(b),
        .BUSY(busy),
        .DONE(done),
        .PRODUCT(product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int lat_of(input logic [W-1:0] bv);
`ifdef SEQ_MUL_ZERO_SKIP_EN
        return W + $countones(bv);
`else
        return 2 * W + 0 * $countones(bv);
`endif
    endfunction

    // Called away from a rising edge; returns #1 after the accepting edge.
    task automatic launch(input logic [W-1:0] av, input logic [W-1:0] bv);
        start = 1'b1;
        a     = av;
        b     = bv;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = W'($urandom);
        b     = W'($urandom);
    endtask

    // Samples on falling edges after each rising edge following acceptance.
    task automatic expect_op(input string tag, input logic [2*W-1:0] exp, input int lat,
                             input int poke, input bit chain,
                             input logic [W-1:0] ca, input logic [W-1:0] cb);
        int bad_busy = 0;
        for (int i = 1; i <= lat; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (i < lat && (busy !== 1'b1 || done !== 1'b0)) bad_busy++;
            if (poke != 0 && i == poke) begin
                start = 1'b1;
                a     = 8'd1;
                b     = 8'd1;
            end
            if (poke != 0 && i == poke + 1) start = 1'b0;
            if (chain && i == lat - 1) begin
                start = 1'b1;
                a     = ca;
                b     = cb;
            end
        end
        chk({tag, "_busy_span"}, bad_busy, 0);
        chk({tag, "_done"}, {31'd0, done}, 1);
        chk({tag, "_busy_at_done"}, {31'd0, busy}, 0);
        chk({tag, "_product"}, {16'd0, product}, {16'd0, exp});
        if (chain) begin
            @(posedge clk);
            #1;
            start = 1'b0;
        end else begin
            @(posedge clk);
            @(negedge clk);
            chk({tag, "_done_pulse"}, {31'd0, done}, 0);
            chk({tag, "_held"}, {16'd0, product}, {16'd0, exp});
        end
    endtask

    initial begin
        int seen_done;
        rst_n = 1'b0;
        start = 1'b1;
        a     = 8'd13;
        b     = 8'd11;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_product", {16'd0, product}, 0);
        rst_n = 1'b1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("idle_busy", {31'd0, busy}, 0);
        chk("idle_product", {16'd0, product}, 0);

        launch(8'd13, 8'd11);
        expect_op("mul_13x11", 16'd143, lat_of(8'd11), 0, 1'b0, 8'd0, 8'd0);

        launch(8'd255, 8'd255);
        expect_op("mul_255x255", 16'hFE01, lat_of(8'd255), 0, 1'b0, 8'd0, 8'd0);

        launch(8'd200, 8'd0);
        expect_op("mul_200x0", 16'd0, lat_of(8'd0), 0, 1'b0, 8'd0, 8'd0);

        launch(8'd0, 8'd255);
        expect_op("mul_0x255", 16'd0, lat_of(8'd255), 0, 1'b0, 8'd0, 8'd0);

        launch(8'd13, 8'd11);
        expect_op("ignore_start", 16'd143, lat_of(8'd11), 3, 1'b0, 8'd0, 8'd0);

        launch(8'd13, 8'd11);
        for (int i = 1; i <= 5; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_busy", {31'd0, busy}, 0);
        chk("midrst_done", {31'd0, done}, 0);
        chk("midrst_product", {16'd0, product}, 0);
        rst_n = 1'b1;
        seen_done = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) seen_done++;
        end
        chk("midrst_stays_idle", seen_done, 0);
        launch(8'd7, 8'd9);
        expect_op("mul_7x9", 16'd63, lat_of(8'd9), 0, 1'b0, 8'd0, 8'd0);

        launch(8'd13, 8'd11);
        expect_op("b2b_first", 16'd143, lat_of(8'd11), 0, 1'b1, 8'd3, 8'd5);
        expect_op("b2b_second", 16'd15, lat_of(8'd5), 0, 1'b0, 8'd0, 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_mul_ctrl.md
Name: seq_mul_ctrl

Overview:
- Multicycle unsigned shift-and-add multiplier sequencer for the multicycle CPU datapath.
- Drives the shared 8-function ALU in its ADD mode (ALU_CTRL=3'b000) and a right-shifting accumulator/multiplier register pair.
- Takes a one-cycle START request with operands and returns a 2W-bit product with a one-cycle DONE pulse.
- Sits beside the main control unit, which stalls on BUSY.

Parameters:
- W, 8: operand width in bits; W >= 2. Product width is 2W.

Ports:
- CLK  input  1  rising-edge clock
- RST_N  input  1  synchronous reset, active-low, sampled on the CLK rising edge
- START  input  1  request; sampled only in IDLE or DONE_ST
- A  input  W  multiplicand; captured when START is accepted
- B  input  W  multiplier; captured when START is accepted
- BUSY  output  1  high while the operation runs (states ADD, SHIFT)
- DONE  output  1  one-cycle pulse; PRODUCT is valid in that cycle
- PRODUCT  output  2W  result {ACC, MQ}; held until the next accepted START or reset

Behaviour:
- Internal state:
  - MCAND[W-1:0]: multiplicand register.
  - ACC[W-1:0]: upper half of the product.
  - MQ[W-1:0]: multiplier, shifted out to become the lower half.
  - C: 1-bit carry.
  - CNT: iteration counter, $clog2(W)+1 bits.
- Reset (RST_N=0 at an edge), from any state including mid-operation:
  - state=IDLE.
  - ACC, MQ, MCAND, C, CNT = 0.
  - BUSY=0, DONE=0, PRODUCT=0.
- FSM states: IDLE, ADD, SHIFT, DONE_ST.
- IDLE:
  - START=1 → MCAND<=A, MQ<=B, ACC<=0, C<=0, CNT<=0; go to ADD.
  - Otherwise stay.
- ADD:
  - If MQ[0]=1: {C,ACC} <= ACC+MCAND, using the ALU add with carry-out.
  - Else: ACC unchanged, C<=0.
  - Go to SHIFT.
- SHIFT:
  - {C,ACC,MQ} <= {1'b0,C,ACC,MQ[W-1:1]}, a logical right shift by 1.
  - CNT<=CNT+1.
  - If CNT==W-1 go to DONE_ST, else go to ADD.
- DONE_ST:
  - DONE=1 for exactly this cycle.
  - START=1 → load exactly as in IDLE and go to ADD (back-to-back operation).
  - Otherwise go to IDLE.
- Outputs:
  - BUSY=1 exactly in ADD and SHIFT.
  - BUSY=0 in IDLE and DONE_ST.
  - PRODUCT={ACC,MQ} at all times; it changes only in ADD/SHIFT/load cycles.
- Latency: START accepted at edge k gives DONE high in the cycle following edge k+2W. For W=8, DONE is sampled high at edge k+17.
- START while BUSY=1 is ignored, with no effect on operands or timing.
- A and B are don't-care except at the accepting edge.
- Width rules:
  - The carry from the ACC+MCAND add is never lost; it enters ACC[W-1] on the following shift.
  - The maximum product (2^W-1)^2 must fit exactly in 2W bits.
- No signed operation; operands are unsigned.

Optional Feature:
- Macro: SEQ_MUL_ZERO_SKIP_EN
- Defined:
  - In ADD, if MQ[0]=0, perform the SHIFT action in that same cycle (including CNT update and exit check) and skip the SHIFT state.
  - Latency becomes W + popcount(B) cycles from the accepting edge to the DONE cycle.
  - PRODUCT value is unchanged.
- Undefined: fixed 2W-cycle latency as above, independent of operand values.

Test Plan:
- Reset: hold RST_N=0 for 2 cycles with START=1 → BUSY=0, DONE=0, PRODUCT=16'h0000. Release → stays IDLE until START.
- W=8, A=13, B=11, single START:
  - PRODUCT=16'd143.
  - DONE high exactly 16 cycles after the accepting edge; 11 cycles with SEQ_MUL_ZERO_SKIP_EN (popcount=3).
  - BUSY high every cycle in between.
- A=255, B=255 → PRODUCT=16'd65025 (16'hFE01); exercises the carry path every iteration.
- A=200, B=0 → PRODUCT=0 after 16 cycles (8 with the macro). A=0, B=255 → PRODUCT=0.
- Pulse START again while BUSY at cycle 3 with A=1, B=1 → ignored; first result 143 is still produced.
- Reset mid-operation at cycle 5 → IDLE, PRODUCT=0, no DONE. Then A=7, B=9 → 63.
- Back-to-back: assert START with A=3, B=5 in the DONE_ST cycle of a prior 13×11 operation → 143 seen with DONE, then BUSY re-asserts next cycle, then 15 with a second DONE pulse.
